// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory access with req/ready handshake, stall and fault detection
//
// Purpose:
//   Issues loads/stores from the EX/MEM register to a variable-latency data
//   memory, stalls the pipeline while an access is outstanding, flags
//   misaligned / illegal / timed-out accesses and passes writeback control
//   through to MEM/WB.
//
// Optional feature macro: MEM_STAGE_PERF_EN
//   Defined   -> stall_cycles counts stalled cycles (saturating, cleared by reset).
//   Undefined -> stall_cycles is tied to zero and no counter is built.
//
// Parameters:
//   TIMEOUT             max WAIT cycles before an access is aborted (2..255)
//
// Ports:
//   clk, rst            pipeline clock; synchronous active-low reset
//   *_EX_MEM            address/ALU result, store data, PC+2, control, dest reg
//   mem_req/mem_wr      request and direction to data memory
//   mem_addr/mem_wdata  address and store data to data memory
//   mem_rdata/mem_ready read data and completion from data memory
//   stall               hold EX/MEM and upstream, bubble into MEM/WB
//   memData             load data to MEM/WB
//   *_MEM               pass-through writeback control (isRegWrite gated by err)
//   err                 one-cycle fault pulse
//   stall_cycles        stall performance counter

module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluResult_EX_MEM,
  input  logic [15:0] rdData2_EX_MEM,
  input  logic [15:0] PC_2_EX_MEM,
  input  logic        isMemRead_EX_MEM,
  input  logic        isMemWrite_EX_MEM,
  input  logic        isMemToReg_EX_MEM,
  input  logic        isRegWrite_EX_MEM,
  input  logic        isNotHalt_EX_MEM,
  input  logic [2:0]  writeRegSel_EX_MEM,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [15:0] memData,
  output logic [15:0] aluResult_MEM,
  output logic [15:0] PC_2_MEM,
  output logic        isMemToReg_MEM,
  output logic        isNotHalt_MEM,
  output logic        isRegWrite_MEM,
  output logic [2:0]  writeRegSel_MEM,
  output logic        err,
  output logic [15:0] stall_cycles
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_next_cnt;
  logic [15:0] r_rdata_q;

  logic w_access;
  logic w_fault;
  logic w_req;
  logic w_stall;
  logic w_err;
  logic w_complete;

  assign w_access = isNotHalt_EX_MEM & (isMemRead_EX_MEM | isMemWrite_EX_MEM);
  // Misaligned word address or read+write both requested.
  assign w_fault  = aluResult_EX_MEM[0] | (isMemRead_EX_MEM & isMemWrite_EX_MEM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_rdata_q  <= 16'h0000;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
      if (w_complete && isMemRead_EX_MEM)
        r_rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_wait_cnt;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    w_err        = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_fault) begin
            w_err = 1'b1;
          end else begin
            w_req = 1'b1;
            if (mem_ready) begin
              w_complete = 1'b1;
            end else begin
              w_stall      = 1'b1;
              w_next_state = S_WAIT;
              w_next_cnt   = 8'd1;
            end
          end
        end
      end
      S_WAIT: begin
        // EX/MEM is frozen by stall, so the request fields stay stable here.
        w_req = 1'b1;
        if (mem_ready) begin
          w_complete   = 1'b1;
          w_next_state = S_IDLE;
          w_next_cnt   = 8'd0;
        end else if (r_wait_cnt == LP_TIMEOUT) begin
          w_req        = 1'b0;
          w_err        = 1'b1;
          w_next_state = S_IDLE;
          w_next_cnt   = 8'd0;
        end else begin
          w_stall    = 1'b1;
          w_next_cnt = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 8'd0;
      end
    endcase
    // Reset silences the handshake and also keeps read data out of memData.
    if (!rst) begin
      w_req      = 1'b0;
      w_stall    = 1'b0;
      w_err      = 1'b0;
      w_complete = 1'b0;
    end
  end

  assign mem_req         = w_req;
  assign mem_wr          = isMemWrite_EX_MEM;
  assign mem_addr        = aluResult_EX_MEM;
  assign mem_wdata       = rdData2_EX_MEM;
  assign stall           = w_stall;
  assign err             = w_err;
  assign memData         = (w_complete && isMemRead_EX_MEM) ? mem_rdata : r_rdata_q;
  assign aluResult_MEM   = aluResult_EX_MEM;
  assign PC_2_MEM        = PC_2_EX_MEM;
  assign isMemToReg_MEM  = isMemToReg_EX_MEM;
  assign isNotHalt_MEM   = isNotHalt_EX_MEM;
  assign isRegWrite_MEM  = isRegWrite_EX_MEM & ~w_err;
  assign writeRegSel_MEM = writeRegSel_EX_MEM;

`ifdef MEM_STAGE_PERF_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rst)
      r_stall_cycles <= 16'h0000;
    else if (w_stall && (r_stall_cycles != 16'hFFFF))
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu, wdata_in, pc2;
  logic        rd, wr, m2r, rw, nh;
  logic [2:0]  wsel;
  logic [15:0] rdata;
  logic        ready;

  // Instance A: TIMEOUT=4
  logic        a_req, a_wr, a_stall, a_m2r, a_nh, a_rw, a_err;
  logic [15:0] a_addr, a_wdata, a_mdata, a_alu, a_pc2, a_sc;
  logic [2:0]  a_wsel;
  // Instance B: TIMEOUT=8 (long enough for the 5-wait load)
  logic        b_req, b_wr, b_stall, b_m2r, b_nh, b_rw, b_err;
  logic [15:0] b_addr, b_wdata, b_mdata, b_alu, b_pc2, b_sc;
  logic [2:0]  b_wsel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(4)) u_dut_a (
    .clk(clk), .rst(rst), .aluResult_EX_MEM(alu), .rdData2_EX_MEM(wdata_in),
    .PC_2_EX_MEM(pc2), .isMemRead_EX_MEM(rd), .isMemWrite_EX_MEM(wr),
    .isMemToReg_EX_MEM(m2r), .isRegWrite_EX_MEM(rw), .isNotHalt_EX_MEM(nh),
    .writeRegSel_EX_MEM(wsel), .mem_req(a_req), .mem_wr(a_wr), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(rdata), .mem_ready(ready), .stall(a_stall),
    .memData(a_mdata), .aluResult_MEM(a_alu), .PC_2_MEM(a_pc2),
    .isMemToReg_MEM(a_m2r), .isNotHalt_MEM(a_nh), .isRegWrite_MEM(a_rw),
    .writeRegSel_MEM(a_wsel), .err(a_err), .stall_cycles(a_sc)
  );

  mem_access_stage #(.TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst(rst), .aluResult_EX_MEM(alu), .rdData2_EX_MEM(wdata_in),
    .PC_2_EX_MEM(pc2), .isMemRead_EX_MEM(rd), .isMemWrite_EX_MEM(wr),
    .isMemToReg_EX_MEM(m2r), .isRegWrite_EX_MEM(rw), .isNotHalt_EX_MEM(nh),
    .writeRegSel_EX_MEM(wsel), .mem_req(b_req), .mem_wr(b_wr), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(rdata), .mem_ready(ready), .stall(b_stall),
    .memData(b_mdata), .aluResult_MEM(b_alu), .PC_2_MEM(b_pc2),
    .isMemToReg_MEM(b_m2r), .isNotHalt_MEM(b_nh), .isRegWrite_MEM(b_rw),
    .writeRegSel_MEM(b_wsel), .err(b_err), .stall_cycles(b_sc)
  );

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    alu = 16'h0000; wdata_in = 16'h0000; pc2 = 16'h0000;
    rd = 1'b0; wr = 1'b0; m2r = 1'b0; rw = 1'b0; nh = 1'b1;
    wsel = 3'd0; rdata = 16'h0000; ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    alu = 16'h0010; rd = 1'b1; rw = 1'b1;
    #1;
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", a_req); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", a_stall); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", a_err); end
    cyc();
    rst = 1'b1;
    drive_idle();
    #1;
    checks++; if (a_mdata !== 16'h0000) begin errors++; $display("FAIL rst_memdata: got %h expected 0000", a_mdata); end
    checks++; if (a_sc !== 16'h0000) begin errors++; $display("FAIL rst_stall_cycles: got %h expected 0000", a_sc); end
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", a_req); end
    cyc();
  endtask

  task automatic test_load_zero_wait();
    drive_idle();
    alu = 16'h0010; rd = 1'b1; rw = 1'b1; m2r = 1'b1; pc2 = 16'h0102; wsel = 3'd5;
    ready = 1'b1; rdata = 16'hBEEF;
    #1;
    checks++; if (a_req !== 1'b1) begin errors++; $display("FAIL ld0_req: got %b expected 1", a_req); end
    checks++; if (a_wr !== 1'b0) begin errors++; $display("FAIL ld0_wr: got %b expected 0", a_wr); end
    checks++; if (a_addr !== 16'h0010) begin errors++; $display("FAIL ld0_addr: got %h expected 0010", a_addr); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL ld0_stall: got %b expected 0", a_stall); end
    checks++; if (a_mdata !== 16'hBEEF) begin errors++; $display("FAIL ld0_memdata: got %h expected beef", a_mdata); end
    checks++; if (a_rw !== 1'b1) begin errors++; $display("FAIL ld0_regwrite: got %b expected 1", a_rw); end
    checks++; if ({a_pc2, a_wsel, a_m2r, a_nh} !== {16'h0102, 3'd5, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ld0_passthru: got %h/%0d/%b/%b expected 0102/5/1/1", a_pc2, a_wsel, a_m2r, a_nh);
    end
    cyc();
    drive_idle();
    #1;
    checks++; if (a_mdata !== 16'hBEEF) begin errors++; $display("FAIL ld0_hold: got %h expected beef", a_mdata); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL ld0_after_stall: got %b expected 0", a_stall); end
    cyc();
  endtask

  task automatic test_store_wait3();
    int nstall;
    nstall = 0;
    drive_idle();
    alu = 16'h0020; wdata_in = 16'h1234; wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (a_stall === 1'b1) nstall++;
      checks++; if ({a_req, a_wr, a_wdata, a_addr, a_err} !== {1'b1, 1'b1, 16'h1234, 16'h0020, 1'b0}) begin
        errors++; $display("FAIL st3_hold[%0d]: got req=%b wr=%b wd=%h a=%h err=%b expected 1 1 1234 0020 0", i, a_req, a_wr, a_wdata, a_addr, a_err);
      end
      cyc();
    end
    ready = 1'b1;
    #1;
    checks++; if (nstall !== 3) begin errors++; $display("FAIL st3_stall_count: got %0d expected 3", nstall); end
    checks++; if ({a_req, a_stall, a_err} !== 3'b100) begin
      errors++; $display("FAIL st3_complete: got req/stall/err=%b%b%b expected 100", a_req, a_stall, a_err);
    end
    cyc();
    drive_idle();
    #1;
    checks++; if ({a_req, a_stall} !== 2'b00) begin errors++; $display("FAIL st3_idle: got %b%b expected 00", a_req, a_stall); end
    cyc();
  endtask

  task automatic test_faults();
    drive_idle();
    alu = 16'h0021; rd = 1'b1; rw = 1'b1; ready = 1'b1; rdata = 16'h5555;
    #1;
    checks++; if ({a_err, a_req, a_stall, a_rw} !== 4'b1000) begin
      errors++; $display("FAIL misalign: got err/req/stall/rw=%b%b%b%b expected 1000", a_err, a_req, a_stall, a_rw);
    end
    checks++; if (a_mdata !== 16'hBEEF) begin errors++; $display("FAIL misalign_memdata: got %h expected beef", a_mdata); end
    cyc();
    drive_idle();
    #1;
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b expected 0", a_err); end
    cyc();
    alu = 16'h0030; rd = 1'b1; wr = 1'b1; rw = 1'b1;
    #1;
    checks++; if ({a_err, a_req, a_stall, a_rw} !== 4'b1000) begin
      errors++; $display("FAIL illegal: got err/req/stall/rw=%b%b%b%b expected 1000", a_err, a_req, a_stall, a_rw);
    end
    cyc();
    drive_idle();
    cyc();
  endtask

  task automatic test_timeout();
    drive_idle();
    alu = 16'h0040; rd = 1'b1; rw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({a_req, a_stall, a_err} !== 3'b110) begin
        errors++; $display("FAIL to_wait[%0d]: got req/stall/err=%b%b%b expected 110", i, a_req, a_stall, a_err);
      end
      cyc();
    end
    #1;
    checks++; if ({a_err, a_stall, a_req, a_rw} !== 4'b1000) begin
      errors++; $display("FAIL to_abort: got err/stall/req/rw=%b%b%b%b expected 1000", a_err, a_stall, a_req, a_rw);
    end
    cyc();
    drive_idle();
    #1;
    checks++; if ({a_req, a_stall, a_err} !== 3'b000) begin
      errors++; $display("FAIL to_after: got req/stall/err=%b%b%b expected 000", a_req, a_stall, a_err);
    end
    cyc();
    // Back in IDLE: a zero-wait load goes straight through.
    alu = 16'h0042; rd = 1'b1; ready = 1'b1; rdata = 16'hA5A5;
    #1;
    checks++; if ({a_req, a_stall, a_mdata} !== {1'b1, 1'b0, 16'hA5A5}) begin
      errors++; $display("FAIL to_idle_load: got req=%b stall=%b md=%h expected 1 0 a5a5", a_req, a_stall, a_mdata);
    end
    cyc();
    drive_idle();
    cyc();
  endtask

  task automatic test_halt();
    drive_idle();
    nh = 1'b0; rd = 1'b1; rw = 1'b1; alu = 16'h0050;
    #1;
    checks++; if ({a_req, a_stall, a_err, a_rw, a_nh} !== 5'b00010) begin
      errors++; $display("FAIL halt: got req/stall/err/rw/nh=%b%b%b%b%b expected 00010", a_req, a_stall, a_err, a_rw, a_nh);
    end
    cyc();
    drive_idle();
    cyc();
  endtask

  task automatic test_reset_mid_wait();
    drive_idle();
    alu = 16'h0060; rd = 1'b1; rw = 1'b1;
    cyc();
    cyc();
    #1;
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL rmw_in_wait: got %b expected 1", a_stall); end
    rst = 1'b0;
    #1;
    checks++; if ({a_req, a_stall, a_err} !== 3'b000) begin
      errors++; $display("FAIL rmw_forced: got req/stall/err=%b%b%b expected 000", a_req, a_stall, a_err);
    end
    cyc();
    rst = 1'b1;
    drive_idle();
    #1;
    checks++; if ({a_req, a_stall, a_err, a_mdata} !== {3'b000, 16'h0000}) begin
      errors++; $display("FAIL rmw_after: got req=%b stall=%b err=%b md=%h expected 0 0 0 0000", a_req, a_stall, a_err, a_mdata);
    end
    cyc();
  endtask

  task automatic test_perf();
    logic [15:0] exp_sc;
    do_reset();
    drive_idle();
    alu = 16'h0070; rd = 1'b1; rw = 1'b1;
    cyc(); cyc();
    ready = 1'b1; rdata = 16'h1111;
    cyc();
    drive_idle();
    cyc();
    alu = 16'h0072; rd = 1'b1; rw = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    ready = 1'b1; rdata = 16'h2222;
    #1;
    checks++; if ({b_stall, b_mdata} !== {1'b0, 16'h2222}) begin
      errors++; $display("FAIL perf_b_complete: got stall=%b md=%h expected 0 2222", b_stall, b_mdata);
    end
    cyc();
    drive_idle();
    #1;
`ifdef MEM_STAGE_PERF_EN
    exp_sc = 16'd7;
`else
    exp_sc = 16'd0;
`endif
    checks++; if (b_sc !== exp_sc) begin errors++; $display("FAIL perf_count: got %0d expected %0d", b_sc, exp_sc); end
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    cyc();
    test_reset();
    test_load_zero_wait();
    test_store_wait3();
    test_faults();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
